// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered one-hot grant
// and a hold timer that force-releases long grants.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic       busy,
  output logic       expired
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d, owner_q, owner_d, sel;
  logic [7:0] cnt_q, cnt_d, grant_q, grant_d;
  logic       busy_q, busy_d, expired_q, expired_d, rel;
  always_comb begin
    sel = ptr_q;
    for (int i = 7; i >= 0; i--) if (req[ptr_q + 3'(i)]) sel = ptr_q + 3'(i);
    rel = done | ~req[owner_q] | (cnt_q == 8'(MAX_HOLD - 1));
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    expired_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        owner_d = sel;
        grant_d = 8'd1 << sel;
        busy_d  = 1'b1;
        cnt_d   = 8'd0;
      end
    end else if (rel) begin
      state_d   = IDLE;
      grant_d   = 8'd0;
      busy_d    = 1'b0;
      ptr_d     = owner_q + 3'd1;
      // a timer release only counts as expiry when nothing else caused it
      expired_d = ~done & req[owner_q];
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      owner_q   <= 3'd0;
      cnt_q     <= 8'd0;
      grant_q   <= 8'd0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign expired = expired_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed stimulus against a cycle-level behavioural model of
// the round-robin arbiter, plus literal checks that pin the model.
module tb_rr_arbiter8;
  localparam int MH = 16;
  logic       clk = 1'b0, rst = 1'b1, done = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant, grant1;
  logic       busy, expired, busy1, expired1;
  int         n_tests = 0, n_fail = 0;
  int         m_own, m_ptr, m_held;
  bit         m_exp;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .busy(busy), .expired(expired));
  rr_arbiter8 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant1), .busy(busy1), .expired(expired1));

  always #5 clk = ~clk;

  // model: owner index or -1, cycles the grant has been visible, rotating pointer
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_ptr = 0; m_held = 0; m_exp = 0;
    end else if (m_own < 0) begin
      m_exp = 0;
      for (int i = 0; i < 8; i++) if (m_own < 0 && req[(m_ptr + i) % 8]) m_own = (m_ptr + i) % 8;
      m_held = 1;
    end else if (done || !req[m_own] || m_held == MH) begin
      m_exp = !done && req[m_own];
      m_ptr = (m_own + 1) % 8;
      m_own = -1;
    end else begin
      m_held++;
      m_exp = 0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] mg;
    if (!rst) begin
      mg = (m_own < 0) ? 8'h00 : 8'(1 << m_own);
      n_tests++;
      if (grant !== mg || busy !== (m_own >= 0) || expired !== m_exp) begin
        n_fail++;
        $display("FAIL model t=%0t grant=%h busy=%b expired=%b expected grant=%h busy=%b expired=%b",
          $time, grant, busy, expired, mg, m_own >= 0, m_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_grant", grant, 8'h00);
    chk("reset_flags", {6'b0, busy, expired}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_grant", grant, 8'h00);
    chk("reset_flags", {6'b0, busy, expired}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h08;
    tick(1);
    chk("single_grant", grant, 8'h08);
    chk("hold1_grant", grant1, 8'h08);
    tick(1);
    chk("single_hold", grant, 8'h08);
    chk("hold1_release", grant1, 8'h00);
    chk("hold1_expired", {7'b0, expired1}, 8'h01);
    tick(1);
    chk("single_hold3", grant, 8'h08);
    done = 1'b1;
    tick(1);
    chk("single_release", grant, 8'h00);
    done = 1'b0;
    req = 8'h11;
    tick(1);
    chk("ptr_after_done", grant, 8'h10);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    req = 8'h00;
    do_reset();
    req = 8'hFF;
    for (int j = 0; j < 9; j++) begin
      tick(1);
      chk("rr_grant", grant, 8'(1 << (j % 8)));
      done = 1'b1;
      tick(1);
      chk("rr_gap", grant, 8'h00);
      done = 1'b0;
    end
    req = 8'h20;
    tick(1);
    chk("to_first", grant, 8'h20);
    tick(15);
    chk("to_last", grant, 8'h20);
    tick(1);
    chk("to_gap", grant, 8'h00);
    chk("to_expired", {7'b0, expired}, 8'h01);
    tick(1);
    chk("to_regrant", grant, 8'h20);
    chk("to_exp_pulse", {7'b0, expired}, 8'h00);
    req = 8'h00;
    tick(1);
    chk("drop_release", grant, 8'h00);
    chk("drop_noexp", {7'b0, expired}, 8'h00);
    do_reset();
    req = 8'h21;
    tick(1);
    chk("prio_first", grant, 8'h01);
    tick(16);
    chk("prio_gap", grant, 8'h00);
    tick(1);
    chk("prio_second", grant, 8'h20);
    tick(16);
    chk("prio_gap2", grant, 8'h00);
    tick(1);
    chk("prio_third", grant, 8'h01);
    req = 8'h00;
    do_reset();
    req = 8'h04;
    tick(1);
    chk("drop4_grant", grant, 8'h04);
    req = 8'h00;
    tick(1);
    chk("drop4_release", grant, 8'h00);
    chk("drop4_noexp", {7'b0, expired}, 8'h00);
    req = 8'h04;
    tick(16);
    chk("both_last", grant, 8'h04);
    done = 1'b1;
    tick(1);
    chk("both_release", grant, 8'h00);
    chk("both_noexp", {7'b0, expired}, 8'h00);
    done = 1'b0;
    req = 8'h00;
    do_reset();
    req = 8'h40;
    tick(2);
    chk("async_pre", grant, 8'h40);
    #2 rst = 1'b1;
    #1;
    chk("async_grant", grant, 8'h00);
    chk("async_busy", {7'b0, busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    req = 8'hFF;
    tick(1);
    chk("async_after", grant, 8'h01);
    req = 8'h00;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
